// File: rtl/conv_pkg.sv
// Shared definitions for the conv_window_mac streaming convolution engine.
// Holds the width helpers for the per-term product and the accumulator,
// the shift-amount width and the stride encoding.
package conv_pkg;

  localparam int SHIFT_W = 5;

  typedef enum logic {
    STRIDE_1 = 1'b0,
    STRIDE_2 = 1'b1
  } stride_e;

  // (im - zp) is IMG_W+1 bits signed; times a WGT_W-bit signed weight.
  function automatic int prod_w(input int img_w, input int wgt_w);
    return img_w + wgt_w + 1;
  endfunction

  // Enough headroom that the sum over ch*k*k products cannot overflow.
  function automatic int acc_w(input int img_w, input int wgt_w,
                               input int ch, input int k);
    return prod_w(img_w, wgt_w) + $clog2(ch * k * k);
  endfunction

endpackage

// File: rtl/conv_window_mac_if.sv
// Column/result bus of conv_window_mac.
//   master : feeder side (drives the column and control, receives results)
//   slave  : engine side
// Signals: i_start, i_valid, i_inhibit, i_stride, i_shift, i_zp,
//          i_col_im, i_col_ker (column in), o_valid, o_conv (result out).
interface conv_window_mac_if
  import conv_pkg::*;
#(
  parameter int K     = 3,
  parameter int CH    = 1,
  parameter int IMG_W = 8,
  parameter int WGT_W = 4,
  parameter int OUT_W = 16
);
  logic                     i_start;
  logic                     i_valid;
  logic                     i_inhibit;
  logic                     i_stride;
  logic [SHIFT_W-1:0]       i_shift;
  logic [IMG_W-1:0]         i_zp;
  logic [CH*K*IMG_W-1:0]    i_col_im;
  logic [CH*K*WGT_W-1:0]    i_col_ker;
  logic                     o_valid;
  logic [OUT_W-1:0]         o_conv;

  modport master (
    output i_start, i_valid, i_inhibit, i_stride, i_shift, i_zp,
           i_col_im, i_col_ker,
    input  o_valid, o_conv
  );

  modport slave (
    input  i_start, i_valid, i_inhibit, i_stride, i_shift, i_zp,
           i_col_im, i_col_ker,
    output o_valid, o_conv
  );
endinterface

// File: rtl/conv_adder_tree.sv
// Signed N-input adder with a registered output (pipeline stage S2).
// Ports: clk, rstn (async active-low), en (stage advance), in_valid,
//        in_data[N] (signed IN_W), out_valid, out_sum (signed OUT_W).
module conv_adder_tree #(
  parameter int N     = 9,
  parameter int IN_W  = 13,
  parameter int OUT_W = 17
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data [N],
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_sum
);

  logic signed [OUT_W-1:0] total;

  always_comb begin
    total = '0;
    for (int unsigned i = 0; i < N; i++) begin
      total = total + OUT_W'(in_data[i]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_sum   <= total;
    end
  end

endmodule

// File: rtl/conv_window_mac.sv
// Streaming KxK convolution MAC. Takes one K-row column per channel per
// cycle, builds the window internally and emits one zero-point-corrected,
// rounded, reduced multiply-accumulate result per complete window
// (every other window at stride 2). Pipeline: S0 window, S1 products,
// S2 sum (conv_adder_tree), S3 shift/round/reduce into o_conv.
// Ports: clk, rstn (async active-low), bus (conv_window_mac_if.slave).
// Build option: SATURATE_EN clamps the result to OUT_W signed range;
// otherwise the result wraps to its low OUT_W bits.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int K     = 3,
  parameter int CH    = 1,
  parameter int IMG_W = 8,
  parameter int WGT_W = 4,
  parameter int OUT_W = 16
) (
  input logic              clk,
  input logic              rstn,
  conv_window_mac_if.slave bus
);

  localparam int N     = CH * K * K;
  localparam int PW    = prod_w(IMG_W, WGT_W);
  localparam int ACC_W = acc_w(IMG_W, WGT_W, CH, K);
  localparam int FW    = $clog2(K + 1);

  // S0: window, column 0 oldest, column K-1 newest
  logic        [IMG_W-1:0] win_im  [CH][K][K];
  logic signed [WGT_W-1:0] win_ker [CH][K][K];
  logic [FW-1:0]           fill;
  logic                    phase;
  logic                    v0;

  logic                    accept, complete, emit, phase_base;
  logic [FW-1:0]           fill_base, fill_inc;

  // A start in the same cycle as an accepted column counts that column as 1.
  always_comb begin
    accept     = bus.i_valid && !bus.i_inhibit;
    fill_base  = bus.i_start ? '0 : fill;
    phase_base = bus.i_start ? 1'b0 : phase;
    fill_inc   = (fill_base == FW'(K)) ? fill_base : fill_base + 1'b1;
    complete   = (fill_inc == FW'(K));
    emit       = complete && ((bus.i_stride == STRIDE_1) || !phase_base);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill  <= '0;
      phase <= 1'b0;
      v0    <= 1'b0;
      for (int unsigned c = 0; c < CH; c++)
        for (int unsigned r = 0; r < K; r++)
          for (int unsigned j = 0; j < K; j++) begin
            win_im[c][r][j]  <= '0;
            win_ker[c][r][j] <= '0;
          end
    end else if (!bus.i_inhibit) begin
      v0 <= accept && emit;
      if (accept) begin
        fill  <= fill_inc;
        phase <= complete ? !phase_base : phase_base;
        for (int unsigned c = 0; c < CH; c++)
          for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned j = 0; j < K - 1; j++) begin
              win_im[c][r][j]  <= win_im[c][r][j+1];
              win_ker[c][r][j] <= win_ker[c][r][j+1];
            end
            win_im[c][r][K-1]  <= bus.i_col_im[(c*K+r)*IMG_W +: IMG_W];
            win_ker[c][r][K-1] <= bus.i_col_ker[(c*K+r)*WGT_W +: WGT_W];
          end
      end else if (bus.i_start) begin
        fill  <= '0;
        phase <= 1'b0;
      end
    end
  end

  // S1: per-term products
  logic signed [PW-1:0] prod_d [N];
  logic signed [PW-1:0] prod_q [N];
  logic                 v1;

  always_comb begin
    logic signed [IMG_W:0] d;
    logic signed [PW-1:0]  dx, kx;
    prod_d = '{default: '0};
    for (int unsigned c = 0; c < CH; c++)
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned j = 0; j < K; j++) begin
          d  = $signed({1'b0, win_im[c][r][j]}) - $signed({1'b0, bus.i_zp});
          dx = PW'(d);
          kx = PW'(win_ker[c][r][j]);
          prod_d[(c*K+r)*K+j] = dx * kx;
        end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1 <= 1'b0;
      for (int unsigned i = 0; i < N; i++) prod_q[i] <= '0;
    end else if (!bus.i_inhibit) begin
      v1 <= v0;
      for (int unsigned i = 0; i < N; i++) prod_q[i] <= prod_d[i];
    end
  end

  // S2: sum
  logic                    v2;
  logic signed [ACC_W-1:0] sum;

  conv_adder_tree #(
    .N     (N),
    .IN_W  (PW),
    .OUT_W (ACC_W)
  ) u_adder_tree (
    .clk       (clk),
    .rstn      (rstn),
    .en        (!bus.i_inhibit),
    .in_valid  (v1),
    .in_data   (prod_q),
    .out_valid (v2),
    .out_sum   (sum)
  );

  // S3: round-half-up shift. floor((x + 2^(s-1)) / 2^s) equals
  // (x >>> s) plus bit s-1 of x; the sign-extended copy keeps that bit
  // select in range for any shift amount.
  logic signed [ACC_W+31:0] sx;
  logic signed [ACC_W-1:0]  sh, r;
  logic                     rb;
  logic [OUT_W-1:0]         red;

  always_comb begin
    sx = (ACC_W+32)'(sum);
    sh = ACC_W'(sx >>> bus.i_shift);
    rb = (bus.i_shift != '0) ? sx[bus.i_shift - 1'b1] : 1'b0;
    r  = sh + ACC_W'(rb);
  end

  if (OUT_W >= ACC_W) begin : g_extend
    always_comb red = OUT_W'(r);
  end else begin : g_reduce
`ifdef SATURATE_EN
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(64'sd1 <<< (OUT_W-1)));
    always_comb begin
      if (r > MAXV)      red = {1'b0, {(OUT_W-1){1'b1}}};
      else if (r < MINV) red = {1'b1, {(OUT_W-1){1'b0}}};
      else               red = r[OUT_W-1:0];
    end
`else
    always_comb red = r[OUT_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.o_valid <= 1'b0;
      bus.o_conv  <= '0;
    end else if (bus.i_inhibit) begin
      bus.o_valid <= 1'b0;
    end else begin
      bus.o_valid <= v2;
      if (v2) bus.o_conv <= red;
    end
  end

endmodule
